// File: rtl/rc_pkg.sv
// ---------------------------------------------------------------------------
// rc_pkg
//   Shared types and helpers for the row/column move decoder.
//   - rc_state_t : decoder FSM states
//   - ILL_*      : illegal_code values reported on a rejected move
//   - rc_index   : 1-based (row, col) to cell bit index on an n*n board.
//                  (1,1) maps to the MSB and (n,n) to bit 0.
// ---------------------------------------------------------------------------
package rc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        COMMIT = 3'd2,
        REJECT = 3'd3,
        FULL   = 3'd4
    } rc_state_t;

    localparam logic [1:0] ILL_NONE     = 2'b00;
    localparam logic [1:0] ILL_RANGE    = 2'b01;
    localparam logic [1:0] ILL_OCCUPIED = 2'b10;

    // Column-major with column 1 in the top bits; matches the board store layout.
    function automatic int rc_index(input int n, input int row, input int col);
        return n * n - 1 - ((col - 1) * n + (row - 1));
    endfunction

endpackage

// File: rtl/rc_cell_index.sv
// ---------------------------------------------------------------------------
// rc_cell_index
//   Combinational (row, col) -> {range_ok, one-hot cell strobe}.
//   Ports:
//     row, col  in  CW     1-based coordinates (0 is never valid)
//     range_ok  out 1      both coordinates within 1..N
//     onehot    out N*N    single bit set at rc_index(N,row,col), zero if out of range
// ---------------------------------------------------------------------------
module rc_cell_index
    import rc_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [CW-1:0]  row,
    input  logic [CW-1:0]  col,
    output logic           range_ok,
    output logic [N*N-1:0] onehot
);

    localparam logic [CW-1:0] NMAX = CW'(N);

    always_comb begin
        range_ok = (row != '0) && (row <= NMAX) && (col != '0) && (col <= NMAX);
        onehot   = '0;
        // Gating with range_ok keeps the strobe zero for coordinates whose
        // formula result would alias onto a real cell.
        for (int i = 0; i < N * N; i++) begin
            onehot[i] = range_ok && (rc_index(N, int'(row), int'(col)) == i);
        end
    end

endmodule

// File: rtl/rc_move_decoder.sv
// ---------------------------------------------------------------------------
// rc_move_decoder
//   Turns a (row, col) move request into a one-hot N*N cell write strobe,
//   with handshake, range/occupancy checking, alternating players,
//   per-player occupancy masks, board-full detection and new-game clear.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for move_valid; move_ready=1, coordinates latched on accept
//   CHECK  | latched coordinates evaluated for range and occupancy
//   COMMIT | write strobe issued, mask updated, player toggled, count++
//   REJECT | illegal pulse issued with its code, nothing else changes
//   FULL   | every cell occupied; requests ignored until clear/reset
//
//   Ports:
//     clk, reset    clock, synchronous active-high reset
//     clear         synchronous new-game clear (same priority as reset)
//     move_valid/move_ready   request handshake, row/col sampled on accept
//     cell_we       one-hot write strobe (1-cycle), cell_player owns it
//     player        player to move next
//     mask_p0/p1    cells held by each player
//     illegal       1-cycle reject pulse, illegal_code held until next accept
//     board_full    all cells occupied
//     move_count    accepted (committed) moves since reset/clear
// ---------------------------------------------------------------------------
module rc_move_decoder
    import rc_pkg::*;
#(
    parameter int N            = 3,
    parameter bit FIRST_PLAYER = 1'b0,
    localparam int CW          = $clog2(N + 1),
    localparam int CELLS       = N * N,
    localparam int MCW         = $clog2(N * N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             move_valid,
    output logic             move_ready,
    input  logic [CW-1:0]    row,
    input  logic [CW-1:0]    col,
    output logic [CELLS-1:0] cell_we,
    output logic             cell_player,
    output logic             player,
    output logic [CELLS-1:0] mask_p0,
    output logic [CELLS-1:0] mask_p1,
    output logic             illegal,
    output logic [1:0]       illegal_code,
    output logic             board_full,
    output logic [MCW-1:0]   move_count
);

    localparam logic [MCW-1:0] LAST_MOVE = MCW'(CELLS - 1);

    rc_state_t        state;
    logic [CW-1:0]    row_q;
    logic [CW-1:0]    col_q;
    logic             range_ok;
    logic [CELLS-1:0] cell_hot;
    logic             occupied;

    rc_cell_index #(
        .N  (N),
        .CW (CW)
    ) u_cell_index (
        .row      (row_q),
        .col      (col_q),
        .range_ok (range_ok),
        .onehot   (cell_hot)
    );

    assign occupied = |(cell_hot & (mask_p0 | mask_p1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state        <= IDLE;
            // Ready stays low through the reset cycle; a clear lands straight in IDLE.
            move_ready   <= !reset;
            row_q        <= '0;
            col_q        <= '0;
            cell_we      <= '0;
            cell_player  <= FIRST_PLAYER;
            player       <= FIRST_PLAYER;
            mask_p0      <= '0;
            mask_p1      <= '0;
            illegal      <= 1'b0;
            illegal_code <= ILL_NONE;
            board_full   <= 1'b0;
            move_count   <= '0;
        end else begin
            cell_we <= '0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid && move_ready) begin
                        row_q        <= row;
                        col_q        <= col;
                        illegal_code <= ILL_NONE;
                        move_ready   <= 1'b0;
                        state        <= CHECK;
                    end else begin
                        move_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    state <= (range_ok && !occupied) ? COMMIT : REJECT;
                end
                COMMIT: begin
                    cell_we     <= cell_hot;
                    cell_player <= player;
                    if (player) begin
                        mask_p1 <= mask_p1 | cell_hot;
                    end else begin
                        mask_p0 <= mask_p0 | cell_hot;
                    end
                    player     <= !player;
                    move_count <= move_count + MCW'(1);
                    if (move_count == LAST_MOVE) begin
                        board_full <= 1'b1;
                        move_ready <= 1'b0;
                        state      <= FULL;
                    end else begin
                        move_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                REJECT: begin
                    illegal      <= 1'b1;
                    // Out-of-range takes precedence: an invalid coordinate has no cell to be occupied.
                    illegal_code <= range_ok ? ILL_OCCUPIED : ILL_RANGE;
                    move_ready   <= 1'b1;
                    state        <= IDLE;
                end
                FULL: begin
                    move_ready <= 1'b0;
                end
                default: begin
                    move_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc_move_decoder.sv
// ---------------------------------------------------------------------------
// tb_rc_move_decoder
//   Scoreboard bench for rc_move_decoder (N=3) plus a directed pass on an
//   N=4 instance. The driver pushes the hand-computed response of each move;
//   a negedge monitor pops and compares whenever cell_we or illegal appears.
// ---------------------------------------------------------------------------
module tb_rc_move_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic [1:0] row = '0;
    logic [1:0] col = '0;
    logic [8:0] cell_we;
    logic       cell_player;
    logic       player;
    logic [8:0] mask_p0;
    logic [8:0] mask_p1;
    logic       illegal;
    logic [1:0] illegal_code;
    logic       board_full;
    logic [3:0] move_count;

    rc_move_decoder #(.N(3), .FIRST_PLAYER(1'b0)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .move_valid   (move_valid),
        .move_ready   (move_ready),
        .row          (row),
        .col          (col),
        .cell_we      (cell_we),
        .cell_player  (cell_player),
        .player       (player),
        .mask_p0      (mask_p0),
        .mask_p1      (mask_p1),
        .illegal      (illegal),
        .illegal_code (illegal_code),
        .board_full   (board_full),
        .move_count   (move_count)
    );

    logic        clear4 = 1'b0;
    logic        valid4 = 1'b0;
    logic        ready4;
    logic [2:0]  row4 = '0;
    logic [2:0]  col4 = '0;
    logic [15:0] we4;
    logic        cplayer4;
    logic        player4;
    logic [15:0] m0_4;
    logic [15:0] m1_4;
    logic        illegal4;
    logic [1:0]  code4;
    logic        full4;
    logic [4:0]  count4;

    rc_move_decoder #(.N(4), .FIRST_PLAYER(1'b0)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear4),
        .move_valid   (valid4),
        .move_ready   (ready4),
        .row          (row4),
        .col          (col4),
        .cell_we      (we4),
        .cell_player  (cplayer4),
        .player       (player4),
        .mask_p0      (m0_4),
        .mask_p1      (m1_4),
        .illegal      (illegal4),
        .illegal_code (code4),
        .board_full   (full4),
        .move_count   (count4)
    );

    typedef struct {
        logic [8:0] we;
        logic       ill;
        logic [1:0] code;
        logic       cp;
        logic       pl;
        logic [3:0] cnt;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic       exp_player = 1'b0;
    logic [3:0] exp_count = '0;
    logic [8:0] exp_m0 = '0;
    logic [8:0] exp_m1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (cell_we != '0 || illegal)) begin
            chk("we_onehot", 32'($onehot0(cell_we)), 32'd1);
            chk("mask_disjoint", 32'(mask_p0 & mask_p1), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_we", 32'(cell_we), 32'd0);
                chk("unexpected_illegal", 32'(illegal), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("cell_we", 32'(cell_we), 32'(mon_e.we));
                chk("illegal", 32'(illegal), 32'(mon_e.ill));
                chk("illegal_code", 32'(illegal_code), 32'(mon_e.code));
                if (!mon_e.ill) chk("cell_player", 32'(cell_player), 32'(mon_e.cp));
                chk("player", 32'(player), 32'(mon_e.pl));
                chk("move_count", 32'(move_count), 32'(mon_e.cnt));
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic wait_ready3();
        int n;
        n = 0;
        @(negedge clk);
        while (!move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!move_ready) chk("ready_timeout", 32'(move_ready), 32'd1);
    endtask

    // code = 0 means an accepted move writing 'we'; otherwise a rejection.
    task automatic move3(input logic [1:0] r, input logic [1:0] c,
                         input logic [8:0] we, input logic [1:0] code);
        exp_t e;
        wait_ready3();
        row = r;
        col = c;
        move_valid = 1'b1;
        e.we   = (code == 2'b00) ? we : 9'h000;
        e.ill  = (code != 2'b00);
        e.code = code;
        e.cp   = exp_player;
        if (code == 2'b00) begin
            if (exp_player) exp_m1 = exp_m1 | we;
            else            exp_m0 = exp_m0 | we;
            exp_player = ~exp_player;
            exp_count  = exp_count + 4'd1;
        end
        e.pl  = exp_player;
        e.cnt = exp_count;
        e.cyc = cyc + 3;
        q.push_back(e);
        @(posedge clk);
        #1 move_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mask_p0", 32'(mask_p0), 32'(exp_m0));
        chk("mask_p1", 32'(mask_p1), 32'(exp_m1));
    endtask

    task automatic move4(input logic [2:0] r, input logic [2:0] c, output logic [15:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready4) chk("n4_ready_timeout", 32'(ready4), 32'd1);
        row4 = r;
        col4 = c;
        valid4 = 1'b1;
        @(posedge clk);
        #1 valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        w = we4;
    endtask

    logic [1:0] fill_r [9] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic [1:0] fill_c [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [8:0] fill_w [9] = '{9'h100, 9'h080, 9'h040, 9'h020, 9'h010,
                               9'h008, 9'h004, 9'h002, 9'h001};

    initial begin
        logic [15:0] w;
        int k;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(move_ready), 32'd0);
        chk("rst_we", 32'(cell_we), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_code", 32'(illegal_code), 32'd0);
        chk("rst_masks", 32'(mask_p0 | mask_p1), 32'd0);
        chk("rst_full", 32'(board_full), 32'd0);
        chk("rst_count", 32'(move_count), 32'd0);
        chk("rst_player", 32'(player), 32'd0);
        chk("rst_cplayer", 32'(cell_player), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(move_ready), 32'd1);

        // Basic moves, occupancy and range rejections
        move3(2'd1, 2'd1, 9'h100, 2'b00);
        move3(2'd3, 2'd3, 9'h001, 2'b00);
        move3(2'd3, 2'd3, 9'h000, 2'b10);
        move3(2'd0, 2'd2, 9'h000, 2'b01);
        move3(2'd2, 2'd3, 9'h002, 2'b00);
        chk("code_cleared_on_accept", 32'(illegal_code), 32'd0);
        chk("player_before_clear", 32'(player), 32'd1);

        // Clear during CHECK of (2,2): write aborted
        wait_ready3();
        row = 2'd2;
        col = 2'd2;
        move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(negedge clk);
        exp_m0 = '0; exp_m1 = '0; exp_player = 1'b0; exp_count = '0;
        chk("clr_masks", 32'(mask_p0 | mask_p1), 32'd0);
        chk("clr_player", 32'(player), 32'd0);
        chk("clr_count", 32'(move_count), 32'd0);
        chk("clr_ready", 32'(move_ready), 32'd1);

        // Out-of-range on the N=3 board uses coordinate 4 (needs CW=2: max 3), so test via 0
        move3(2'd2, 2'd0, 9'h000, 2'b01);
        chk("range_code_held", 32'(illegal_code), 32'd1);

        // Fill the board alternately
        for (int i = 0; i < 9; i++) move3(fill_r[i], fill_c[i], fill_w[i], 2'b00);
        chk("full_flag", 32'(board_full), 32'd1);
        chk("full_ready", 32'(move_ready), 32'd0);
        chk("full_union", 32'(mask_p0 | mask_p1), 32'h1FF);
        chk("full_p0", 32'(mask_p0), 32'h155);
        chk("full_p1", 32'(mask_p1), 32'h0AA);
        chk("full_count", 32'(move_count), 32'd9);

        // Requests while full are ignored
        @(negedge clk);
        row = 2'd1;
        col = 2'd1;
        move_valid = 1'b1;
        repeat (5) @(negedge clk);
        move_valid = 1'b0;
        chk("ignored_count", 32'(move_count), 32'd9);
        chk("ignored_ready", 32'(move_ready), 32'd0);

        // Clear with a simultaneous request: request dropped
        @(negedge clk);
        row = 2'd3;
        col = 2'd3;
        move_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        move_valid = 1'b0;
        exp_m0 = '0; exp_m1 = '0; exp_player = 1'b0; exp_count = '0;
        repeat (3) @(negedge clk);
        chk("clr2_full", 32'(board_full), 32'd0);
        chk("clr2_count", 32'(move_count), 32'd0);
        chk("clr2_masks", 32'(mask_p0 | mask_p1), 32'd0);
        move3(2'd1, 2'd1, 9'h100, 2'b00);

        // N=4 instance
        k = 0;
        for (int c = 1; c <= 4; c++) begin
            for (int r = 1; r <= 4; r++) begin
                move4(3'(r), 3'(c), w);
                if (k == 0)  chk("n4_1_1", 32'(w), 32'h8000);
                if (k == 1)  chk("n4_2_1", 32'(w), 32'h4000);
                if (k == 15) chk("n4_4_4", 32'(w), 32'h0001);
                k++;
            end
        end
        chk("n4_full", 32'(full4), 32'd1);
        chk("n4_count", 32'(count4), 32'd16);
        chk("n4_ready", 32'(ready4), 32'd0);
        chk("n4_union", 32'(m0_4 | m1_4), 32'hFFFF);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
